// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back, read-port and debug-dump signal bundle for wb_regfile.
// Rev 1.0
`default_nettype none

interface wb_regfile_if #(
   parameter int XLEN = 32,
   parameter int IDXW = 5
);
   logic [IDXW-1:0] WriteBackNum;
   logic            WriteBackReg;
   logic [XLEN-1:0] WriteBackData;
   logic [IDXW-1:0] ReadNum1;
   logic [XLEN-1:0] ReadData1;
   logic [IDXW-1:0] ReadNum2;
   logic [XLEN-1:0] ReadData2;
   logic            DumpStart;
   logic            DumpValid;
   logic            DumpReady;
   logic [IDXW-1:0] DumpIdx;
   logic [XLEN-1:0] DumpData;
   logic            DumpBusy;

   modport master (
      output WriteBackNum, WriteBackReg, WriteBackData,
      output ReadNum1, ReadNum2, DumpStart, DumpReady,
      input  ReadData1, ReadData2, DumpValid, DumpIdx, DumpData, DumpBusy
   );

   modport slave (
      input  WriteBackNum, WriteBackReg, WriteBackData,
      input  ReadNum1, ReadNum2, DumpStart, DumpReady,
      output ReadData1, ReadData2, DumpValid, DumpIdx, DumpData, DumpBusy
   );
endinterface

`default_nettype wire

// File: rtl/wb_regfile.sv
// wb_regfile: x0..x31 register file with write-first bypass reads and a debug dump sequencer.
// Rev 1.0
`default_nettype none

module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_regfile_if.slave  bus
);
   localparam int              IDXW       = $clog2(NREGS);
   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NREGS - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_DUMP = 1'b1
   } state_t;

   logic [XLEN-1:0] r_regs [NREGS];
   state_t          r_state;
   logic            r_dump_valid;
   logic            r_dump_busy;
   logic [IDXW-1:0] r_dump_idx;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (bus.WriteBackReg && (bus.WriteBackNum != '0)) begin
         r_regs[bus.WriteBackNum] <= bus.WriteBackData;
      end
   end

   always_comb begin
      w_rd1 = r_regs[bus.ReadNum1];
      if (!rst_n || (bus.ReadNum1 == '0)) begin
         w_rd1 = '0;
      end else if (bus.WriteBackReg && (bus.WriteBackNum == bus.ReadNum1)) begin
         w_rd1 = bus.WriteBackData;
      end
   end

   always_comb begin
      w_rd2 = r_regs[bus.ReadNum2];
      if (!rst_n || (bus.ReadNum2 == '0)) begin
         w_rd2 = '0;
      end else if (bus.WriteBackReg && (bus.WriteBackNum == bus.ReadNum2)) begin
         w_rd2 = bus.WriteBackData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_dump_valid <= 1'b0;
         r_dump_busy  <= 1'b0;
         r_dump_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.DumpStart) begin
                  r_state      <= S_DUMP;
                  r_dump_valid <= 1'b1;
                  r_dump_busy  <= 1'b1;
                  r_dump_idx   <= '0;
               end
            end
            S_DUMP: begin
               if (bus.DumpReady) begin
                  if (r_dump_idx == C_LAST_IDX) begin
                     r_state      <= S_IDLE;
                     r_dump_valid <= 1'b0;
                     r_dump_busy  <= 1'b0;
                     r_dump_idx   <= '0;
                  end else begin
                     r_dump_idx <= r_dump_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_dump_valid <= 1'b0;
               r_dump_busy  <= 1'b0;
               r_dump_idx   <= '0;
            end
         endcase
      end
   end

   assign bus.ReadData1 = w_rd1;
   assign bus.ReadData2 = w_rd2;
   assign bus.DumpValid = r_dump_valid;
   assign bus.DumpBusy  = r_dump_busy;
   assign bus.DumpIdx   = r_dump_idx;
   // Dump shows committed contents only; a stalled beat follows later writes.
   assign bus.DumpData  = r_dump_valid ? r_regs[r_dump_idx] : '0;
endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: vector table, random model comparison and dump sequences for wb_regfile.
// Rev 1.0
`default_nettype none

module tb_wb_regfile;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [31:0] model [32];

   typedef struct {
      logic        we;
      logic [4:0]  wnum;
      logic [31:0] wdata;
      logic [4:0]  rn1;
      logic [4:0]  rn2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [8];

   wb_regfile_if #(.XLEN(32), .IDXW(5)) bus ();

   wb_regfile #(.XLEN(32), .NREGS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mread(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.WriteBackReg && bus.WriteBackNum == idx) return bus.WriteBackData;
      return model[idx];
   endfunction

   // Commit the pending write into the model, then advance one clock.
   task automatic tick();
      if (rst_n && bus.WriteBackReg && bus.WriteBackNum != 5'd0)
         model[bus.WriteBackNum] = bus.WriteBackData;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   task automatic write_reg(input logic [4:0] n, input logic [31:0] d);
      bus.WriteBackReg  = 1'b1;
      bus.WriteBackNum  = n;
      bus.WriteBackData = d;
      tick();
      bus.WriteBackReg  = 1'b0;
   endtask

   task automatic check_beat(input string tag, input int idx);
      check($sformatf("%s valid@%0d", tag, idx), {31'd0, bus.DumpValid}, 32'd1);
      check($sformatf("%s idx@%0d", tag, idx), {27'd0, bus.DumpIdx}, idx);
      check($sformatf("%s data@%0d", tag, idx), bus.DumpData, (idx == 0) ? 32'd0 : model[idx]);
   endtask

   task automatic start_dump();
      bus.DumpStart = 1'b1;
      tick();
      bus.DumpStart = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_model();
      rst_n             = 1'b0;
      bus.WriteBackReg  = 1'b0;
      bus.WriteBackNum  = 5'd0;
      bus.WriteBackData = 32'd0;
      bus.ReadNum1      = 5'd0;
      bus.ReadNum2      = 5'd0;
      bus.DumpStart     = 1'b0;
      bus.DumpReady     = 1'b0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      tick();

      // Asynchronous reset mid-cycle, with a bypass write pending on the bus
      write_reg(5'd3, 32'h0000_0077);
      bus.ReadNum1 = 5'd3;
      #1 check("pre-reset x3", bus.ReadData1, 32'h0000_0077);
      #2 rst_n = 1'b0;
      bus.WriteBackReg  = 1'b1;
      bus.WriteBackNum  = 5'd3;
      bus.WriteBackData = 32'h0000_0099;
      bus.ReadNum2      = 5'd3;
      #1;
      check("reset rd1", bus.ReadData1, 32'd0);
      check("reset rd2", bus.ReadData2, 32'd0);
      check("reset valid", {31'd0, bus.DumpValid}, 32'd0);
      check("reset busy", {31'd0, bus.DumpBusy}, 32'd0);
      check("reset idx", {27'd0, bus.DumpIdx}, 32'd0);
      check("reset data", bus.DumpData, 32'd0);
      bus.WriteBackReg = 1'b0;
      clear_model();
      #1 rst_n = 1'b1;
      for (int i = 1; i < 32; i++) begin
         bus.ReadNum1 = 5'(i);
         bus.ReadNum2 = 5'(32 - i);
         #1;
         check($sformatf("post-reset rd1 x%0d", i), bus.ReadData1, 32'd0);
         check($sformatf("post-reset rd2 x%0d", 32 - i), bus.ReadData2, 32'd0);
      end
      tick();

      // Basic write/read and x0 immunity
      write_reg(5'd5, 32'hDEAD_BEEF);
      bus.ReadNum1 = 5'd5;
      #1 check("x5 read", bus.ReadData1, 32'hDEAD_BEEF);
      write_reg(5'd0, 32'h0000_1234);
      bus.ReadNum2 = 5'd0;
      #1 check("x0 read", bus.ReadData2, 32'd0);

      // Bypass vectors; each row is presented, checked, then clocked
      vecs[0] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[1] = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd5,  32'hA5A5_A5A5, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678};
      vecs[3] = '{1'b0, 5'd7,  32'h0000_0000, 5'd7,  5'd0,  32'h1234_5678, 32'h0000_0000};
      vecs[4] = '{1'b1, 5'd0,  32'h0000_0055, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[6] = '{1'b0, 5'd31, 32'h0000_0000, 5'd31, 5'd1,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[7] = '{1'b1, 5'd5,  32'h0000_0001, 5'd5,  5'd5,  32'h0000_0001, 32'h0000_0001};
      for (int v = 0; v < 8; v++) begin
         bus.WriteBackReg  = vecs[v].we;
         bus.WriteBackNum  = vecs[v].wnum;
         bus.WriteBackData = vecs[v].wdata;
         bus.ReadNum1      = vecs[v].rn1;
         bus.ReadNum2      = vecs[v].rn2;
         #1;
         check($sformatf("vec%0d rd1", v), bus.ReadData1, vecs[v].exp1);
         check($sformatf("vec%0d rd2", v), bus.ReadData2, vecs[v].exp2);
         tick();
      end
      bus.WriteBackReg = 1'b0;

      // Random traffic against the array model
      for (int c = 0; c < 300; c++) begin
         bus.WriteBackReg  = 1'($urandom_range(0, 1));
         bus.WriteBackNum  = 5'($urandom_range(0, 31));
         bus.WriteBackData = $urandom;
         bus.ReadNum1 = ($urandom_range(0, 3) == 0) ? bus.WriteBackNum : 5'($urandom_range(0, 31));
         bus.ReadNum2 = ($urandom_range(0, 3) == 0) ? bus.WriteBackNum : 5'($urandom_range(0, 31));
         #1;
         check($sformatf("rand%0d rd1", c), bus.ReadData1, mread(bus.ReadNum1));
         check($sformatf("rand%0d rd2", c), bus.ReadData2, mread(bus.ReadNum2));
         tick();
      end
      bus.WriteBackReg = 1'b0;

      // Full dump of xi = i*0x11 with DumpReady held high
      for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h11);
      bus.DumpReady = 1'b1;
      check("idle valid", {31'd0, bus.DumpValid}, 32'd0);
      start_dump();
      for (int b = 0; b < 32; b++) begin
         check($sformatf("dump idx@%0d", b), {27'd0, bus.DumpIdx}, b);
         check($sformatf("dump data@%0d", b), bus.DumpData, 32'(b) * 32'h11);
         check($sformatf("dump busy@%0d", b), {31'd0, bus.DumpBusy}, 32'd1);
         bus.DumpStart = (b == 15);
         tick();
      end
      bus.DumpStart = 1'b0;
      check("dump end busy", {31'd0, bus.DumpBusy}, 32'd0);
      check("dump end valid", {31'd0, bus.DumpValid}, 32'd0);
      check("dump end idx", {27'd0, bus.DumpIdx}, 32'd0);
      tick();
      check("dump stays idle", {31'd0, bus.DumpBusy}, 32'd0);

      // Backpressure at index 10 with a write to the stalled register
      start_dump();
      for (int b = 0; b < 10; b++) tick();
      bus.DumpReady     = 1'b0;
      bus.WriteBackReg  = 1'b1;
      bus.WriteBackNum  = 5'd10;
      bus.WriteBackData = 32'h0000_CAFE;
      #1;
      check("stall0 idx", {27'd0, bus.DumpIdx}, 32'd10);
      check("stall0 data no bypass", bus.DumpData, 32'h0000_00AA);
      tick();
      bus.WriteBackReg = 1'b0;
      for (int s = 1; s < 3; s++) begin
         check($sformatf("stall%0d idx", s), {27'd0, bus.DumpIdx}, 32'd10);
         check($sformatf("stall%0d data", s), bus.DumpData, 32'h0000_CAFE);
         tick();
      end
      bus.DumpReady = 1'b1;
      check_beat("resume", 10);
      tick();
      check_beat("after stall", 11);
      for (int b = 11; b < 20; b++) tick();
      check_beat("pre-abort", 20);

      // Asynchronous reset in the middle of the dump
      #2 rst_n = 1'b0;
      #1;
      check("abort valid", {31'd0, bus.DumpValid}, 32'd0);
      check("abort busy", {31'd0, bus.DumpBusy}, 32'd0);
      check("abort idx", {27'd0, bus.DumpIdx}, 32'd0);
      clear_model();
      #1 rst_n = 1'b1;
      tick();
      start_dump();
      for (int b = 0; b < 32; b++) begin
         check_beat("redump", b);
         check($sformatf("redump zero@%0d", b), bus.DumpData, 32'd0);
         bus.DumpReady = 1'($urandom_range(0, 1)) | (b == 31);
         while (!bus.DumpReady) begin
            tick();
            check($sformatf("redump hold@%0d", b), {27'd0, bus.DumpIdx}, b);
            bus.DumpReady = 1'($urandom_range(0, 1));
         end
         tick();
      end
      check("redump end busy", {31'd0, bus.DumpBusy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
